// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: architectural PC, imem fetch FSM, commit-time next-PC select, retire counter and misalignment trap
module fetch_pc_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            commit,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] branch_offset,
    input  logic [XLEN-1:0] alu_result,
    output logic            misaligned_trap,
    output logic [XLEN-1:0] instret
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;
    state_t          r_state, w_next;
    logic [XLEN-1:0] r_pc, r_inst_pc, r_instret, w_target;
    logic [31:0]     r_inst;
    logic            r_inst_valid, r_trap, w_commit, w_rsp;
    assign w_commit = (r_state == S_HOLD) && commit;
    assign w_rsp    = (r_state == S_WAIT) && imem_rsp_valid;
    always_comb begin
        w_target = pc_sel == 2'd1 ? r_pc + branch_offset :
                   pc_sel == 2'd2 ? alu_result & ~XLEN'(1) : r_pc + XLEN'(4);
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_REQ;
            S_REQ:   w_next = imem_req_ready ? S_WAIT : S_REQ;
            S_WAIT:  w_next = imem_rsp_valid ? S_HOLD : S_WAIT;
            S_HOLD:  w_next = !commit ? S_HOLD : w_target[1] ? S_TRAP : S_REQ;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_trap       <= 1'b0;
            r_instret    <= '0;
        end else begin
            r_state <= w_next;
            if (w_rsp) begin
                r_inst       <= imem_rsp_data;
                r_inst_pc    <= r_pc;
                r_inst_valid <= 1'b1;
            end
            if (w_commit) begin
                r_instret    <= r_instret + XLEN'(1);
                r_inst_valid <= 1'b0;
                if (w_target[1]) r_trap <= 1'b1;
                else r_pc <= w_target;
            end
        end
    end
    assign imem_req_valid  = r_state == S_REQ;
    assign imem_addr       = r_pc;
    assign inst_valid      = r_inst_valid;
    assign inst            = r_inst;
    assign inst_pc         = r_inst_pc;
    assign misaligned_trap = r_trap;
    assign instret         = r_instret;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: randomized bench for fetch_pc_unit with a behavioural imem and architectural PC model
module tb_fetch_pc_unit;
    localparam logic [31:0] RST_PC = 32'h100;
    logic        clk = 0, rst = 1, imem_req_ready = 1, commit = 0;
    logic [1:0]  pc_sel = 0;
    logic [31:0] branch_offset = 0, alu_result = 0;
    logic        imem_req_valid, imem_rsp_valid, inst_valid, misaligned_trap;
    logic [31:0] imem_addr, imem_rsp_data, inst, inst_pc, instret;
    int          checks = 0, errors = 0, lat = 1;
    bit          rdy_rand = 0, spur = 0;
    logic [1:0]  cnt = 0;
    logic [31:0] addr_q = 0;
    logic [31:0] m_pc, m_instret;
    bit          m_trap;

    fetch_pc_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .commit(commit), .pc_sel(pc_sel), .branch_offset(branch_offset), .alu_result(alu_result),
        .misaligned_trap(misaligned_trap), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) begin
        if (rst) cnt <= 0;
        else if (imem_req_valid && imem_req_ready) begin
            cnt    <= 2'(lat);
            addr_q <= imem_addr;
        end else if (cnt != 0) cnt <= cnt - 1;
    end
    assign imem_rsp_valid = (cnt == 2'd1) | spur;
    assign imem_rsp_data  = cnt == 2'd1 ? mem(addr_q) : 32'hDEAD_BEEF;

    task automatic do_reset();
        @(negedge clk);
        rst = 1; commit = 0; spur = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        m_pc = RST_PC; m_instret = 0; m_trap = 0;
    endtask

    task automatic wait_hold(input string nm);
        int n = 0;
        while (!inst_valid && n < 60) begin
            @(negedge clk);
            imem_req_ready = rdy_rand ? 1'($urandom) : 1'b1;
            #1; n++;
            if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (imem_addr !== m_pc) begin errors++; $display("FAIL %s fetch_addr got %h want %h", nm, imem_addr, m_pc); end
            end
        end
        checks++;
        if (!inst_valid) begin errors++; $display("FAIL %s hold_timeout inst_valid got 0 want 1", nm); end
        else begin
            checks++;
            if (inst !== mem(m_pc) || inst_pc !== m_pc) begin
                errors++; $display("FAIL %s held inst %h pc %h want inst %h pc %h", nm, inst, inst_pc, mem(m_pc), m_pc);
            end
        end
    endtask

    task automatic do_commit(input string nm, input logic [1:0] sel, input logic [31:0] off, input logic [31:0] alu);
        logic [31:0] t;
        t = sel == 2'd1 ? m_pc + off : sel == 2'd2 ? alu & 32'hFFFF_FFFE : m_pc + 32'd4;
        commit = 1; pc_sel = sel; branch_offset = off; alu_result = alu;
        @(posedge clk); #1;
        commit = 0; pc_sel = $urandom; branch_offset = $urandom; alu_result = $urandom;
        m_instret++;
        if (t[1]) m_trap = 1; else m_pc = t;
        checks++;
        if (instret !== m_instret || misaligned_trap !== m_trap || inst_valid !== 1'b0) begin
            errors++; $display("FAIL %s commit instret %h trap %b iv %b want instret %h trap %b iv 0", nm, instret, misaligned_trap, inst_valid, m_instret, m_trap);
        end
        checks++;
        if (imem_req_valid !== !m_trap || (!m_trap && imem_addr !== m_pc)) begin
            errors++; $display("FAIL %s next_req valid %b addr %h want valid %b addr %h", nm, imem_req_valid, imem_addr, !m_trap, m_pc);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (imem_req_valid !== 0 || inst_valid !== 0 || inst !== 0 || inst_pc !== RST_PC || misaligned_trap !== 0 || instret !== 0) begin
            errors++; $display("FAIL reset_values rv %b iv %b inst %h ipc %h trap %b ir %h", imem_req_valid, inst_valid, inst, inst_pc, misaligned_trap, instret);
        end
        @(negedge clk);
        rst = 0; m_pc = RST_PC; m_instret = 0; m_trap = 0;
        #1;
        checks++;
        if (imem_req_valid !== 0) begin errors++; $display("FAIL reset_idle req_valid got %b want 0", imem_req_valid); end
        @(negedge clk); #1;
        checks++;
        if (imem_req_valid !== 1 || imem_addr !== RST_PC) begin
            errors++; $display("FAIL reset_first_req valid %b addr %h want 1 %h", imem_req_valid, imem_addr, RST_PC);
        end
        wait_hold("reset");
        checks++;
        if (instret !== 0) begin errors++; $display("FAIL reset_instret got %h want 0", instret); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            do_commit("seq", 2'd0, 32'h0, 32'h0);
            wait_hold("seq");
        end
        checks++;
        if (instret !== 32'd3 || inst_pc !== 32'h10C) begin
            errors++; $display("FAIL seq_final instret %h pc %h want 3 10c", instret, inst_pc);
        end
    endtask

    task automatic test_branch_jump();
        do_commit("jmp_to_104", 2'd2, 32'h0, 32'h105);
        wait_hold("jmp_to_104");
        do_commit("branch_back", 2'd1, 32'hFFFF_FFFC, 32'h0);
        wait_hold("branch_back");
        checks++;
        if (inst_pc !== 32'h100) begin errors++; $display("FAIL branch_back pc got %h want 100", inst_pc); end
        do_commit("jmp_201", 2'd2, 32'h0, 32'h201);
        wait_hold("jmp_201");
        checks++;
        if (inst_pc !== 32'h200) begin errors++; $display("FAIL jmp_201 pc got %h want 200", inst_pc); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        held = inst;
        spur = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (inst !== held || inst_pc !== m_pc || inst_valid !== 1) begin
            errors++; $display("FAIL spur_hold inst %h pc %h iv %b want %h %h 1", inst, inst_pc, inst_valid, held, m_pc);
        end
        spur = 0;
        imem_req_ready = 0;
        do_commit("bp", 2'd0, 32'h0, 32'h0);
        spur = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (imem_req_valid !== 1 || imem_addr !== m_pc || inst_valid !== 0) begin
                errors++; $display("FAIL bp_stall%0d valid %b addr %h iv %b want 1 %h 0", i, imem_req_valid, imem_addr, inst_valid, m_pc);
            end
        end
        @(negedge clk);
        spur = 0; lat = 3; imem_req_ready = 1;
        @(negedge clk);
        commit = 1;
        #1;
        checks++;
        if (imem_req_valid !== 0 || inst_valid !== 0) begin
            errors++; $display("FAIL wait_state valid %b iv %b want 0 0", imem_req_valid, inst_valid);
        end
        @(negedge clk);
        @(negedge clk);
        commit = 0;
        #1;
        checks++;
        if (instret !== m_instret) begin errors++; $display("FAIL commit_in_wait instret got %h want %h", instret, m_instret); end
        wait_hold("bp");
        lat = 1;
    endtask

    task automatic test_wrap();
        do_commit("to_top", 2'd2, 32'h0, 32'hFFFF_FFFC);
        wait_hold("to_top");
        do_commit("wrap", 2'd0, 32'h0, 32'h0);
        wait_hold("wrap");
        checks++;
        if (inst_pc !== 32'h0) begin errors++; $display("FAIL wrap pc got %h want 0", inst_pc); end
    endtask

    task automatic test_reset_mid_wait();
        lat = 3;
        do_commit("pre_rst", 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        checks++;
        if (imem_req_valid !== 0 || inst_valid !== 0 || inst !== 0 || inst_pc !== RST_PC || misaligned_trap !== 0 || instret !== 0 || imem_addr !== RST_PC) begin
            errors++; $display("FAIL rst_mid_wait rv %b iv %b inst %h ipc %h trap %b ir %h addr %h", imem_req_valid, inst_valid, inst, inst_pc, misaligned_trap, instret, imem_addr);
        end
        @(negedge clk);
        rst = 0; lat = 1;
        m_pc = RST_PC; m_instret = 0; m_trap = 0;
        wait_hold("post_rst");
    endtask

    task automatic test_misaligned();
        do_commit("misalign", 2'd1, 32'h6, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            commit = 1'($urandom); spur = 1'($urandom); imem_req_ready = 1;
            #1;
            checks++;
            if (imem_req_valid !== 0 || misaligned_trap !== 1 || inst_valid !== 0 || instret !== m_instret) begin
                errors++; $display("FAIL trap_idle%0d rv %b trap %b iv %b ir %h want 0 1 0 %h", i, imem_req_valid, misaligned_trap, inst_valid, instret, m_instret);
            end
        end
        commit = 0; spur = 0;
        do_reset();
        #1;
        checks++;
        if (misaligned_trap !== 0 || instret !== 0 || imem_addr !== RST_PC) begin
            errors++; $display("FAIL trap_clear trap %b ir %h addr %h want 0 0 %h", misaligned_trap, instret, imem_addr, RST_PC);
        end
        wait_hold("trap_clear");
    endtask

    task automatic test_random();
        logic [1:0]  sel;
        logic [31:0] off, alu;
        rdy_rand = 1;
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                spur = 1'($urandom);
            end
            @(negedge clk);
            spur = 0; #1;
            lat = $urandom_range(1, 3);
            sel = 2'($urandom);
            off = 32'(($urandom_range(0, 15) - 8) * 4) + (($urandom % 10 == 0) ? 32'd2 : 32'd0);
            alu = {16'h0, 14'($urandom), 2'b00} | (($urandom % 10 == 0) ? 32'd2 : 32'd0) | 32'($urandom % 2);
            do_commit("rand", sel, off, alu);
            if (m_trap) begin
                do_reset();
                wait_hold("rand_rst");
            end else wait_hold("rand");
        end
        rdy_rand = 0;
    endtask

    initial begin
        m_pc = RST_PC; m_instret = 0; m_trap = 0;
        test_reset();
        test_sequential();
        test_branch_jump();
        test_backpressure();
        test_wrap();
        test_reset_mid_wait();
        test_misaligned();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
